// File: rtl/dec_scan_reg_if.sv
// Bus bundle for dec_scan_reg: control/address inputs and decoded outputs.
// master drives control, slave (the decoder) drives D/idx/wrap.
interface dec_scan_reg_if #(
  parameter int N = 5
);
  logic             mode;
  logic [N-1:0]     A;
  logic             En;
  logic             hold;
  logic [0:2**N-1]  D;
  logic [N-1:0]     idx;
  logic             wrap;

  modport master (output mode, A, En, hold, input D, idx, wrap);
  modport slave  (input mode, A, En, hold, output D, idx, wrap);
endinterface

// File: rtl/dec_scan_reg.sv
// Registered N-to-2^N one-hot decoder with polarity select and auto-scan.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_DIRECT | last clocked mode was direct; a mode=1 cycle is a scan entry
// ST_SCAN   | scan running; index steps every DWELL enabled, unheld cycles
module dec_scan_reg #(
  parameter int N          = 5,
  parameter bit ACTIVE_LOW = 1'b0,
  parameter int DWELL      = 4
) (
  input logic          clk,
  input logic          rst,
  dec_scan_reg_if.slave bus
);

  localparam int W  = 2 ** N;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [0:W-1]  INACT    = ACTIVE_LOW ? {W{1'b1}} : {W{1'b0}};
  localparam logic          ACT_BIT  = ~ACTIVE_LOW;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  typedef enum logic {ST_DIRECT, ST_SCAN} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [0:W-1]    d_q, d_d;
  logic            wrap_q, wrap_d;
  logic [N-1:0]    dec_idx;
  logic            sel_en;

  // State and output registers; reset returns to direct with everything inactive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_DIRECT;
      idx_q   <= '0;
      cnt_q   <= '0;
      d_q     <= INACT;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state: direct load, scan entry load, or scan step/freeze.
  always_comb begin
    state_d = bus.mode ? ST_SCAN : ST_DIRECT;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    sel_en  = 1'b0;
    dec_idx = idx_q;

    if (!bus.mode || state_q == ST_DIRECT) begin
      // Direct decode and scan entry share the same load of A; entry beats hold.
      idx_d   = bus.A;
      cnt_d   = '0;
      dec_idx = bus.A;
      sel_en  = bus.En;
    end else if (!bus.En) begin
      sel_en = 1'b0;
    end else if (bus.hold) begin
      sel_en = 1'b1;
    end else begin
      sel_en = 1'b1;
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        idx_d  = idx_q + N'(1);
        wrap_d = (idx_q == {N{1'b1}});
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      dec_idx = idx_d;
    end
  end

  // One-hot decode of the selected index, all inactive when not enabled.
  always_comb begin
    d_d = INACT;
    for (int k = 0; k < W; k++) begin
      if (sel_en && dec_idx == N'(k)) d_d[k] = ACT_BIT;
    end
  end

  assign bus.D    = d_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_dec_scan_reg.sv
// Directed bench for dec_scan_reg: three instances cover active-high N=5,
// active-low N=5 and the degenerate N=1 / DWELL=1 case.
module tb_dec_scan_reg;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dec_scan_reg_if #(.N(5)) b5 ();
  dec_scan_reg_if #(.N(5)) b5l ();
  dec_scan_reg_if #(.N(1)) b1 ();

  dec_scan_reg #(.N(5), .ACTIVE_LOW(1'b0), .DWELL(4)) u5  (.clk(clk), .rst(rst), .bus(b5));
  dec_scan_reg #(.N(5), .ACTIVE_LOW(1'b1), .DWELL(4)) u5l (.clk(clk), .rst(rst), .bus(b5l));
  dec_scan_reg #(.N(1), .ACTIVE_LOW(1'b0), .DWELL(1)) u1  (.clk(clk), .rst(rst), .bus(b1));

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 32-wide one-hot with D[0] as the most significant bit.
  function automatic logic [63:0] oh5(input int k);
    logic [31:0] v;
    v = 32'h8000_0000 >> k;
    return {32'b0, v};
  endfunction

  function automatic logic [63:0] oh5l(input int k);
    logic [31:0] v;
    v = ~(32'h8000_0000 >> k);
    return {32'b0, v};
  endfunction

  function automatic logic [63:0] oh1(input int k);
    return (k == 0) ? 64'h2 : 64'h1;
  endfunction

  // Scan b5 for n cycles checking idx/D/wrap against a fixed index.
  task automatic scan_hold_idx(input string tag, input int n, input int exp_idx);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, "_idx"}, b5.idx, exp_idx);
      chk({tag, "_d"}, b5.D, oh5(exp_idx));
      chk({tag, "_wrap"}, b5.wrap, 0);
    end
  endtask

  initial begin
    int seq [3];
    seq = '{30, 31, 0};

    rst = 1'b1;
    b5.mode = 1'b1;  b5.A = 5'd0;  b5.En = 1'b1;  b5.hold = 1'b0;
    b5l.mode = 1'b0; b5l.A = 5'd0; b5l.En = 1'b1; b5l.hold = 1'b0;
    b1.mode = 1'b0;  b1.A = 1'b0;  b1.En = 1'b0;  b1.hold = 1'b0;

    // Reset state before any clock edge
    #2;
    chk("rst_d", b5.D, 0);
    chk("rst_idx", b5.idx, 0);
    chk("rst_wrap", b5.wrap, 0);
    chk("rst_d_low", b5l.D, 64'hFFFF_FFFF);

    // Direct decode sweep, both polarities; hold is ignored in direct mode
    b5.mode = 1'b0;
    b5.hold = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int a = 0; a < 32; a++) begin
      b5.A  = 5'(a);
      b5l.A = 5'(a);
      #1;
      if (a > 0) chk("dir_latency", b5.D, oh5(a - 1));
      tick();
      chk("dir_d", b5.D, oh5(a));
      chk("dir_idx", b5.idx, a);
      chk("dir_d_low", b5l.D, oh5l(a));
    end
    b5.En  = 1'b0;
    b5l.En = 1'b0;
    tick();
    chk("dir_en0", b5.D, 0);
    chk("dir_en0_low", b5l.D, 64'hFFFF_FFFF);

    // Scan from 30 through wrap to 0 with DWELL=4
    b5.hold = 1'b0;
    b5.En   = 1'b1;
    b5.mode = 1'b1;
    b5.A    = 5'd30;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("scan_idx", b5.idx, seq[i / 4]);
      chk("scan_d", b5.D, oh5(seq[i / 4]));
      chk("scan_wrap", b5.wrap, (i == 8) ? 1 : 0);
    end

    // Hold mid-dwell, then resume with the remaining count
    scan_hold_idx("pre_hold", 2, 1);
    b5.hold = 1'b1;
    scan_hold_idx("hold", 7, 1);
    b5.hold = 1'b0;
    scan_hold_idx("post_hold", 2, 1);
    scan_hold_idx("post_hold_adv", 1, 2);

    // En low freezes idx and blanks D
    b5.En = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en0_d", b5.D, 0);
      chk("en0_idx", b5.idx, 2);
    end
    b5.En = 1'b1;
    scan_hold_idx("en1", 3, 2);
    scan_hold_idx("en1_adv", 1, 3);

    // Mode switching: scan at 12, drop to direct A=3, re-enter at 9 under hold
    b5.mode = 1'b0;
    b5.A    = 5'd12;
    tick();
    b5.mode = 1'b1;
    scan_hold_idx("scan12", 2, 12);
    b5.mode = 1'b0;
    b5.A    = 5'd3;
    tick();
    chk("exit_d", b5.D, oh5(3));
    chk("exit_idx", b5.idx, 3);
    chk("exit_wrap", b5.wrap, 0);
    b5.mode = 1'b1;
    b5.A    = 5'd9;
    b5.hold = 1'b1;
    scan_hold_idx("entry9", 1, 9);
    b5.hold = 1'b0;
    scan_hold_idx("entry9_dwell", 3, 9);
    scan_hold_idx("entry9_adv", 1, 10);

    // Leaving scan exactly when a wrap would fire gives no wrap
    b5.mode = 1'b0;
    b5.A    = 5'd31;
    tick();
    b5.mode = 1'b1;
    scan_hold_idx("pre_exit31", 4, 31);
    b5.mode = 1'b0;
    b5.A    = 5'd5;
    tick();
    chk("exit31_idx", b5.idx, 5);
    chk("exit31_wrap", b5.wrap, 0);
    chk("exit31_d", b5.D, oh5(5));

    // N=1, DWELL=1: index toggles every cycle, wrap on each return to 0
    b1.mode = 1'b1;
    b1.En   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("n1_idx", b1.idx, i % 2);
      chk("n1_d", b1.D, oh1(i % 2));
      chk("n1_wrap", b1.wrap, (i > 0 && i % 2 == 0) ? 1 : 0);
    end

    // Async reset mid-dwell, restart via entry load of A=5
    b5.mode = 1'b1;
    b5.A    = 5'd20;
    scan_hold_idx("pre_rst", 2, 20);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_d", b5.D, 0);
    chk("arst_idx", b5.idx, 0);
    chk("arst_wrap", b5.wrap, 0);
    chk("arst_d_low", b5l.D, 64'hFFFF_FFFF);
    b5.A = 5'd5;
    @(negedge clk);
    rst = 1'b0;
    scan_hold_idx("rst_entry", 4, 5);
    scan_hold_idx("rst_entry_adv", 1, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dec_scan_reg.md
Name: dec_scan_reg

Overview:
Parametrised registered N-to-2^N one-hot decoder with selectable output polarity and an auto-scan mode. In scan mode an internal index counter drives the decoder, stepping through every output in turn at a programmable dwell rate. It is the clocked successor to the combinational decoder tree and is used for multiplexed display digit/row strobing and sequential chip-select generation. Direct mode gives a one-cycle-latency registered decode of an external address.

Parameters:
N, 5, address width; output width is 2^N (legal range 1..6).
ACTIVE_LOW, 0, 0: selected output 1, others 0; 1: selected output 0, others 1.
DWELL, 4, clock cycles each index is held in scan mode (>=1).

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
mode  input  1  0 = direct decode of A; 1 = auto-scan.
A  input  N  address in direct mode; start index on scan entry.
En  input  1  global enable; 0 forces all outputs inactive.
hold  input  1  scan mode only: freeze index and dwell counter.
D  output  [0:2^N-1]  decoded outputs; D[k] selected when index == k.
idx  output  N  index currently decoded (registered).
wrap  output  1  one-cycle pulse when scan index wraps 2^N-1 -> 0.

Behaviour:
- INACT = ACTIVE_LOW ? all-ones : all-zeros. Selected bit = ~INACT bit.
- Reset (async, immediate): D = INACT, idx = 0, wrap = 0, dwell counter = 0, stored previous mode = 0.
- All state is updated on rising clk only. All outputs are registered. No combinational path from inputs to outputs.
- Direct mode (mode=0):
  - Each cycle: idx <= A.
  - D <= En ? onehot(A) : INACT. Latency is exactly 1 cycle.
  - Dwell counter is held at 0. wrap = 0.
- Scan entry (mode 0 -> 1, detected against the registered previous mode):
  - On the first scan cycle: idx <= A, dwell counter <= 0, D <= En ? onehot(A) : INACT.
- Scan running (mode=1, not entry cycle):
  - En=0: D <= INACT; idx and dwell counter frozen; wrap=0.
  - En=1, hold=1: everything frozen; D keeps onehot(idx); wrap=0.
  - En=1, hold=0: dwell counter increments.
    - When the counter reaches DWELL-1, it clears and idx <= idx+1 (mod 2^N). D follows the new idx on the same edge.
    - If idx was 2^N-1, wrap = 1 for that one cycle; otherwise wrap = 0.
  - DWELL=1: idx advances every cycle.
- Scan exit (mode 1 -> 0): direct rules apply immediately. Dwell counter clears and wrap drops to 0.
- Exactly one D bit is active whenever En=1 after the first clock following reset; none are active when En=0.
- Simultaneous events:
  - hold has no effect in direct mode.
  - En=0 takes priority over hold.
  - On the scan-entry cycle, the entry load takes priority over hold.
- N=1: the decoder degenerates to 2 outputs and the index toggles.
- Reset asserted mid-scan returns to the reset state asynchronously. After release, scan restarts via the entry rule only if mode is 1 on the first clock (previous mode reset to 0 forces an entry load).
- Synthesis must not infer latches. The decode is a full case over the index with an INACT default.

Test Plan:
1. Reset check. N=5, ACTIVE_LOW=0. Assert rst with mode=1, En=1 -> D=0, idx=0, wrap=0 immediately, before any clock edge.
2. Direct decode and latency. mode=0, En=1, sweep A=0..31 -> D[A]=1 only, one cycle after each A. Then set En=0 -> D=0 next cycle. Repeat with ACTIVE_LOW=1 -> selected bit 0, all others 1.
3. Scan with dwell. mode=1, A=30, DWELL=4, En=1 -> idx sequence 30 x4 cycles, 31 x4, 0 x4. wrap=1 for exactly the single cycle where idx becomes 0.
4. Hold and enable during scan. Hold=1 for 7 cycles mid-dwell -> idx and D unchanged; dwell resumes from the remaining count afterwards. En=0 for 3 cycles -> D inactive; idx resumes the same value when En returns to 1.
5. Mode switching. Scan at idx=12, switch to mode=0 with A=3 -> D=onehot(3) next cycle, wrap=0. Switch back to mode=1 with A=9 -> idx=9 with a full DWELL before advancing.
6. Edge parameters. N=1, DWELL=1 -> D alternates 10/01 every cycle with wrap on every second cycle. Async reset mid-dwell, then release with mode=1, A=5 -> idx=5 on the first clock.
